// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill controller.
// The optional CACHE_REFILL_PERF_EN feature lives in the top module only.
package cache_pkg;

  localparam int CACHE_ADDR_WIDTH = 32;
  localparam int CACHE_DATA_WIDTH = 32;

  // Wide enough to be truncated to any address width up to 64 bits.
  localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    WR_MEM = 2'd2,
    FILL   = 2'd3
  } refill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, used by the optional performance counters
// (CACHE_REFILL_PERF_EN) of the cache refill controller.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= {CNT_WIDTH{1'b0}};
    end else if (inc_i && (count_o != {CNT_WIDTH{1'b1}})) begin
      count_o <= count_o + CNT_WIDTH'(1);
    end else begin
      count_o <= count_o;
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Read-miss refill and write-through/write-allocate controller behind the data cache.
// Define CACHE_REFILL_PERF_EN to add saturating hit/miss/write counters.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH
`ifdef CACHE_REFILL_PERF_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  fill_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef CACHE_REFILL_PERF_EN
  , output logic [CNT_WIDTH-1:0] read_hits_o
  , output logic [CNT_WIDTH-1:0] read_misses_o
  , output logic [CNT_WIDTH-1:0] writes_o
`endif
);

  refill_state_t         state_r;
  refill_state_t         next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state plus the CPU-facing stall and load result, which must react in the same cycle.
  always_comb begin
    next_state_s = state_r;
    stall_o      = 1'b0;
    rdata_o      = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_valid_i && req_we_i) begin
          next_state_s = WR_MEM;
          stall_o      = 1'b1;
        end else if (req_valid_i && !hit_i) begin
          next_state_s = RD_MEM;
          stall_o      = 1'b1;
        end else if (req_valid_i) begin
          rdata_o = cache_rdata_i;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD_MEM, WR_MEM: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          next_state_s = FILL;
        end else begin
          next_state_s = state_r;
        end
      end
      FILL: begin
        rdata_o      = fill_data_o;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Memory handshake, request latches and the one-cycle fill strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_o <= {DATA_WIDTH{1'b0}};
      fill_o      <= 1'b0;
      fill_addr_o <= {ADDR_WIDTH{1'b0}};
      fill_data_o <= {DATA_WIDTH{1'b0}};
    end else begin
      fill_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (next_state_s != IDLE) begin
            addr_r     <= req_addr_i;
            mem_req_o  <= 1'b1;
            mem_we_o   <= req_we_i;
            mem_addr_o <= req_addr_i & ADDR_WIDTH'(WORD_ALIGN_MASK);
            if (req_we_i) begin
              mem_wdata_o <= req_wdata_i;
            end else begin
              mem_wdata_o <= mem_wdata_o;
            end
          end else begin
            mem_req_o <= 1'b0;
          end
        end
        RD_MEM, WR_MEM: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            fill_o      <= 1'b1;
            fill_addr_o <= addr_r;
            // Write-allocate fills with the store data, not whatever memory returned.
            fill_data_o <= (state_r == WR_MEM) ? mem_wdata_o : mem_rdata_i;
          end else begin
            mem_req_o <= 1'b1;
          end
        end
        FILL: begin
          mem_req_o <= 1'b0;
        end
        default: begin
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_PERF_EN
  logic hit_inc_s;
  logic miss_inc_s;
  logic write_inc_s;

  assign hit_inc_s   = (state_r == IDLE) && req_valid_i && !req_we_i && hit_i;
  assign miss_inc_s  = (state_r == IDLE) && (next_state_s == RD_MEM);
  assign write_inc_s = (state_r == IDLE) && (next_state_s == WR_MEM);

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hits (
    .clk(clk), .rst_n(rst_n), .inc_i(hit_inc_s), .count_o(read_hits_o)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_misses (
    .clk(clk), .rst_n(rst_n), .inc_i(miss_inc_s), .count_o(read_misses_o)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_writes (
    .clk(clk), .rst_n(rst_n), .inc_i(write_inc_s), .count_o(writes_o)
  );
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized self-checking bench for cache_refill_controller against a transaction-level model.
// Inputs change and outputs are sampled around the falling clock edge.
`timescale 1ns/1ps
module tb_cache_refill_controller;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i, req_we_i, hit_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i, cache_rdata_i;
  logic          stall_o, fill_o, mem_req_o, mem_we_o;
  logic [DW-1:0] rdata_o, fill_data_o, mem_wdata_o;
  logic [AW-1:0] fill_addr_o, mem_addr_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0]   read_hits_o, read_misses_o, writes_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned m_hits, m_misses, m_writes;

  cache_refill_controller dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .hit_i(hit_i), .cache_rdata_i(cache_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o),
    .fill_o(fill_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef CACHE_REFILL_PERF_EN
    , .read_hits_o(read_hits_o), .read_misses_o(read_misses_o), .writes_o(writes_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] word_of(input logic [AW-1:0] a);
    return (a >> 2) << 2;
  endfunction

  task automatic idle_cycle(input bit spurious_ack);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom_range(0, 1));
    req_addr_i  = $urandom;
    hit_i       = 1'($urandom_range(0, 1));
    mem_ack_i   = spurious_ack;
    mem_rdata_i = $urandom;
    #1;
    check_eq("idle_stall", stall_o, 0);
    check_eq("idle_rdata", rdata_o, 0);
    check_eq("idle_fill", fill_o, 0);
    check_eq("idle_mem_req", mem_req_o, 0);
  endtask

  task automatic read_hit(input logic [AW-1:0] addr, input logic [DW-1:0] cdata);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
    hit_i = 1'b1; cache_rdata_i = cdata; mem_ack_i = 1'b0;
    #1;
    check_eq("hit_rdata", rdata_o, cdata);
    check_eq("hit_stall", stall_o, 0);
    check_eq("hit_mem_req", mem_req_o, 0);
    check_eq("hit_fill", fill_o, 0);
    m_hits++;
  endtask

  // A miss (is_write=0) or a store (is_write=1); memory acks in wait cycle 'delay'.
  task automatic mem_txn(input bit is_write, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int delay);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = is_write; req_addr_i = addr;
    req_wdata_i = is_write ? data : DW'($urandom);
    hit_i = is_write ? 1'($urandom_range(0, 1)) : 1'b0;
    cache_rdata_i = $urandom; mem_ack_i = 1'b0;
    #1;
    check_eq("req_stall", stall_o, 1);
    check_eq("req_rdata", rdata_o, 0);
    check_eq("req_fill", fill_o, 0);
    if (is_write) m_writes++; else m_misses++;
    for (int i = 1; i <= delay; i++) begin
      @(negedge clk);
      hit_i = 1'($urandom_range(0, 1));
      req_wdata_i = $urandom;
      cache_rdata_i = $urandom;
      mem_ack_i = (i == delay);
      mem_rdata_i = (i == delay && !is_write) ? data : DW'($urandom);
      #1;
      check_eq("wait_stall", stall_o, 1);
      check_eq("wait_mem_req", mem_req_o, 1);
      check_eq("wait_mem_we", mem_we_o, is_write);
      check_eq("wait_mem_addr", mem_addr_o, word_of(addr));
      if (is_write) check_eq("wait_mem_wdata", mem_wdata_o, data);
      check_eq("wait_fill", fill_o, 0);
      check_eq("wait_rdata", rdata_o, 0);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    req_we_i = 1'($urandom_range(0, 1));
    hit_i = 1'b1;
    cache_rdata_i = $urandom;
    #1;
    check_eq("fill_strobe", fill_o, 1);
    check_eq("fill_addr", fill_addr_o, addr);
    check_eq("fill_data", fill_data_o, data);
    check_eq("fill_rdata", rdata_o, data);
    check_eq("fill_stall", stall_o, 0);
    check_eq("fill_mem_req", mem_req_o, 0);
  endtask

  task automatic check_perf();
`ifdef CACHE_REFILL_PERF_EN
    check_eq("perf_hits", read_hits_o, m_hits);
    check_eq("perf_misses", read_misses_o, m_misses);
    check_eq("perf_writes", writes_o, m_writes);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; hit_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; cache_rdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    m_hits = 0; m_misses = 0; m_writes = 0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_mem_we", mem_we_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_mem_wdata", mem_wdata_o, 0);
    check_eq("rst_fill", fill_o, 0);
    check_eq("rst_fill_addr", fill_addr_o, 0);
    check_eq("rst_fill_data", fill_data_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_perf();
    @(negedge clk);
    rst_n = 1'b1;

    read_hit(32'h0000_0010, 32'hDEAD_BEEF);
    mem_txn(1'b0, 32'h0000_0024, 32'h1234_5678, 3);
    mem_txn(1'b1, 32'h0000_0103, 32'hCAFE_F00D, 1);
    idle_cycle(1'b0);

    // Reset while a miss is outstanding; a late ack must not produce a fill.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0200; hit_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_eq("pre_rst_mem_req", mem_req_o, 1);
    end
    @(negedge clk);
    rst_n = 1'b0; req_valid_i = 1'b0;
    #1;
    check_eq("midrst_mem_req", mem_req_o, 0);
    check_eq("midrst_stall", stall_o, 0);
    check_eq("midrst_fill", fill_o, 0);
    m_hits = 0; m_misses = 0; m_writes = 0;
    @(negedge clk);
    rst_n = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    check_eq("late_ack_mem_req", mem_req_o, 0);
    check_eq("late_ack_stall", stall_o, 0);
    idle_cycle(1'b0);

    // Back-to-back miss then hit, spurious ack, hit, store: 2 hits, 1 miss, 1 store.
    mem_txn(1'b0, 32'h0000_0044, 32'h0BAD_F00D, 1);
    read_hit(32'h0000_0048, 32'h5555_AAAA);
    idle_cycle(1'b1);
    read_hit(32'h0000_0050, 32'h0F0F_0F0F);
    mem_txn(1'b1, 32'h0000_0061, 32'hA5A5_5A5A, 2);
    idle_cycle(1'b0);
    check_perf();

    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) read_hit($urandom, $urandom);
      else mem_txn(kind >= 7, $urandom, $urandom, $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);
    check_perf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_controller.md
Name: cache_refill_controller

Overview:
- Sits directly downstream of the two-way data cache, between the cache/CPU load-store path and main data memory.
- On a read miss, it stalls the CPU and fetches the word from memory over a valid/ack handshake. It then pulses the cache overwrite/fill strobe and returns the word.
- All stores are handled write-through with write-allocate: memory is written first, then the cache is filled.
- Read hits pass through with zero added latency.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  CPU load/store request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_WIDTH  CPU byte address.
- req_wdata_i  in  DATA_WIDTH  store data.
- hit_i  in  1  cache hit for req_addr_i (combinational from cache).
- cache_rdata_i  in  DATA_WIDTH  cache read word.
- stall_o  out  1  freeze CPU pipeline.
- rdata_o  out  DATA_WIDTH  load result to CPU.
- fill_o  out  1  one-cycle cache write strobe (drives cache overwrite).
- fill_addr_o  out  ADDR_WIDTH  address for fill.
- fill_data_o  out  DATA_WIDTH  word for fill.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_ack_i  in  1  memory response; single-cycle pulse.
- mem_rdata_i  in  DATA_WIDTH  read data, valid with mem_ack_i.

Behaviour:
- FSM states: IDLE, RD_MEM, WR_MEM, FILL. Reset → IDLE.
- Reset values:
  - all registered outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, fill_o, fill_addr_o, fill_data_o;
  - latched addr/data registers 0;
  - stall_o 0.
- Reset asserted mid-transaction: FSM → IDLE immediately, mem_req_o drops asynchronously, no fill is issued, and the pending transaction is abandoned.
- IDLE:
  - req_valid_i & !req_we_i & hit_i: rdata_o = cache_rdata_i combinationally, stall_o = 0, stay IDLE.
  - req_valid_i & !req_we_i & !hit_i: stall_o = 1 combinationally the same cycle; latch the address; next state RD_MEM with mem_req_o = 1, mem_we_o = 0.
  - req_valid_i & req_we_i, hit or miss: stall_o = 1; latch address and data; next state WR_MEM with mem_req_o = 1, mem_we_o = 1.
  - mem_ack_i in IDLE: ignored.
- RD_MEM:
  - stall_o = 1; mem_req_o, mem_addr_o held stable.
  - On mem_ack_i: capture mem_rdata_i, drop mem_req_o next cycle, go to FILL.
  - Ack in the first RD_MEM cycle is legal (minimum miss penalty 2 cycles of stall).
- WR_MEM:
  - Same handshake as RD_MEM.
  - On mem_ack_i: fill data = latched store data; go to FILL.
- FILL:
  - fill_o = 1 for exactly one cycle, with fill_addr_o = latched address and fill_data_o = captured word.
  - stall_o = 0; rdata_o = captured word. The CPU retires the request this cycle.
  - Next state IDLE.
  - req_valid_i in FILL is not accepted; it is re-evaluated in IDLE next cycle.
- rdata_o outside a valid completion: 0.
- No request queueing: exactly one outstanding memory transaction.

Optional Feature:
- Macro: CACHE_REFILL_PERF_EN.
- When defined, adds outputs read_hits_o, read_misses_o, writes_o (each CNT_WIDTH).
  - read_hits_o increments on a read hit accepted in IDLE.
  - read_misses_o increments on entry to RD_MEM.
  - writes_o increments on entry to WR_MEM.
  - Counters saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package cache_pkg:
  - state enum refill_state_t {IDLE, RD_MEM, WR_MEM, FILL};
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - WORD_ALIGN_MASK constant.
- One natural sub-module, sat_counter (parameter CNT_WIDTH; ports clk, rst_n, inc_i, count_o), instantiated three times under the macro.

Test Plan:
- Read hit: req_valid_i = 1, req_we_i = 0, addr 0x0000_0010, hit_i = 1, cache_rdata_i = 0xDEAD_BEEF → rdata_o = 0xDEAD_BEEF the same cycle; stall_o = 0; mem_req_o stays 0.
- Read miss, ack after 3 cycles: addr 0x0000_0024, hit_i = 0, mem_rdata_i = 0x1234_5678 → stall_o high 4 cycles, mem_addr_o = 0x0000_0024, then fill_o pulse with fill_data_o = 0x1234_5678 and rdata_o = 0x1234_5678, stall_o = 0.
- Store: addr 0x0000_0103, wdata 0xCAFE_F00D, ack after 1 cycle → mem_addr_o = 0x0000_0100, mem_we_o = 1, then fill_o with fill_data_o = 0xCAFE_F00D.
- Reset mid-miss: rst_n low while in RD_MEM → mem_req_o = 0, stall_o = 0, FSM IDLE; a late mem_ack_i produces no fill_o.
- Back-to-back: read miss then immediate read hit → hit serviced in the first IDLE cycle after FILL; spurious mem_ack_i in IDLE ignored.
- CACHE_REFILL_PERF_EN: 2 hits, 1 miss, 1 store → read_hits_o = 2, read_misses_o = 1, writes_o = 1.
